// File: rtl/mac_pipe_param.sv
// rtl/mac_pipe_param.sv - pipelined valid-qualified multiply-add / accumulate unit
// Optional saturation on overflow is enabled by defining MAC_PIPE_SATURATE_EN.
module mac_pipe_param #(
    parameter int IN_W  = 8,
    parameter int C_W   = 16,
    parameter int OUT_W = 16,
    parameter int PIPE  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [IN_W-1:0]     A,
    input  logic [IN_W-1:0]     B,
    input  logic [C_W-1:0]      C,
    input  logic                mode,
    input  logic                acc_clr,
    output logic                out_valid,
    output logic [OUT_W-1:0]    DATA_OUT,
    output logic                ovf
);

    localparam int P_W   = 2 * IN_W;
    localparam int SUM_W = OUT_W + 1;

    if (OUT_W < 2 * IN_W) begin : g_bad_out_w
        $fatal(1, "mac_pipe_param: OUT_W must be >= 2*IN_W");
    end
    if (C_W > OUT_W) begin : g_bad_c_w
        $fatal(1, "mac_pipe_param: C_W must be <= OUT_W");
    end
    if (PIPE < 1) begin : g_bad_pipe
        $fatal(1, "mac_pipe_param: PIPE must be >= 1");
    end

    logic [P_W-1:0] prod_q  [PIPE];
    logic [C_W-1:0] c_q     [PIPE];
    logic           mode_q  [PIPE];
    logic           clr_q   [PIPE];
    logic           valid_q [PIPE];

    logic [P_W-1:0]   prod_d;
    logic [SUM_W-1:0] base;
    logic [SUM_W-1:0] sum;
    logic [OUT_W-1:0] result;

    assign prod_d = {{IN_W{1'b0}}, A} * {{IN_W{1'b0}}, B};

    // Product and its side-band fields travel together so C stays aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE; i++) begin
                prod_q[i]  <= '0;
                c_q[i]     <= '0;
                mode_q[i]  <= 1'b0;
                clr_q[i]   <= 1'b0;
                valid_q[i] <= 1'b0;
            end
        end else begin
            prod_q[0]  <= prod_d;
            c_q[0]     <= C;
            mode_q[0]  <= mode;
            clr_q[0]   <= acc_clr;
            valid_q[0] <= in_valid;
            for (int i = 1; i < PIPE; i++) begin
                prod_q[i]  <= prod_q[i-1];
                c_q[i]     <= c_q[i-1];
                mode_q[i]  <= mode_q[i-1];
                clr_q[i]   <= clr_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    always_comb begin
        base = '0;
        if (mode_q[PIPE-1] && !clr_q[PIPE-1]) begin
            base = {1'b0, DATA_OUT};
        end
        sum = base
            + {{(SUM_W - P_W){1'b0}}, prod_q[PIPE-1]}
            + {{(SUM_W - C_W){1'b0}}, c_q[PIPE-1]};
    end

`ifdef MAC_PIPE_SATURATE_EN
    assign result = sum[OUT_W] ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
`else
    assign result = sum[OUT_W-1:0];
`endif

    // Overflow set takes priority over the acc_clr clear on the same beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DATA_OUT  <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= valid_q[PIPE-1];
            if (valid_q[PIPE-1]) begin
                DATA_OUT <= result;
                if (sum[OUT_W]) begin
                    ovf <= 1'b1;
                end else if (clr_q[PIPE-1]) begin
                    ovf <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_pipe_param.sv
// tb/tb_mac_pipe_param.sv - directed self-checking bench for mac_pipe_param
module tb_mac_pipe_param;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] C;
    logic        mode;
    logic        acc_clr;
    logic        out_valid;
    logic [15:0] DATA_OUT;
    logic        ovf;

    int tests = 0;
    int fails = 0;

`ifdef MAC_PIPE_SATURATE_EN
    localparam logic [15:0] OVF_DIRECT = 16'd65535;
    localparam logic [15:0] OVF_ACC    = 16'd65535;
    localparam logic [15:0] RESAT      = 16'd65535;
`else
    localparam logic [15:0] OVF_DIRECT = 16'd513;
    localparam logic [15:0] OVF_ACC    = 16'd513;
    localparam logic [15:0] RESAT      = 16'd514;
`endif

    mac_pipe_param #(.IN_W(8), .C_W(16), .OUT_W(16), .PIPE(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .C         (C),
        .mode      (mode),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .DATA_OUT  (DATA_OUT),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then land 1ns after the capturing edge.
    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] c, input logic m, input logic clr);
        in_valid = v;
        A        = a;
        B        = b;
        C        = c;
        mode     = m;
        acc_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 8'd0, 16'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; A = '0; B = '0; C = '0; mode = 1'b0; acc_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", out_valid, 0);
        check("reset_data", DATA_OUT, 0);
        check("reset_ovf", ovf, 0);
        rst_n = 1'b1;
        idle(1);

        // Direct beat: 3*4+5 after three edges, then held.
        step(1, 8'd3, 8'd4, 16'd5, 0, 0);
        idle(1);
        check("t1_early_valid", out_valid, 0);
        idle(1);
        check("t1_valid", out_valid, 1);
        check("t1_data", DATA_OUT, 17);
        idle(1);
        check("t1_valid_drop", out_valid, 0);
        check("t1_hold", DATA_OUT, 17);

        // Stream with a bubble.
        step(1, 8'd1, 8'd1, 16'd0, 0, 0);
        step(1, 8'd2, 8'd2, 16'd1, 0, 0);
        step(0, 8'd0, 8'd0, 16'd0, 0, 0);
        check("t2_v0", out_valid, 1);
        check("t2_d0", DATA_OUT, 1);
        step(1, 8'd10, 8'd10, 16'd6, 0, 0);
        check("t2_v1", out_valid, 1);
        check("t2_d1", DATA_OUT, 5);
        idle(1);
        check("t2_v2", out_valid, 0);
        check("t2_d2", DATA_OUT, 5);
        idle(1);
        check("t2_v3", out_valid, 1);
        check("t2_d3", DATA_OUT, 106);
        check("t2_ovf", ovf, 0);

        // Accumulate from a cleared base.
        step(1, 8'd10, 8'd10, 16'd0, 1, 1);
        step(1, 8'd2, 8'd3, 16'd1, 1, 0);
        idle(1);
        check("t3_d0", DATA_OUT, 100);
        idle(1);
        check("t3_valid", out_valid, 1);
        check("t3_d1", DATA_OUT, 107);

        // Direct overflow, then a clean direct beat keeps ovf sticky.
        step(1, 8'd255, 8'd255, 16'd1024, 0, 0);
        step(1, 8'd1, 8'd1, 16'd1, 0, 0);
        idle(1);
        check("t4_data", DATA_OUT, OVF_DIRECT);
        check("t4_ovf", ovf, 1);
        idle(1);
        check("t4_d_after", DATA_OUT, 2);
        check("t4_ovf_sticky", ovf, 1);

        // Accumulate clear resets ovf.
        step(1, 8'd1, 8'd1, 16'd0, 1, 1);
        idle(2);
        check("t5_data", DATA_OUT, 1);
        check("t5_ovf", ovf, 0);

        // Overflow on a clearing beat wins; next accumulate builds on it.
        step(1, 8'd255, 8'd255, 16'd1024, 1, 1);
        step(1, 8'd0, 8'd0, 16'd1, 1, 0);
        idle(1);
        check("t5_clr_ovf_data", DATA_OUT, OVF_ACC);
        check("t5_clr_ovf", ovf, 1);
        idle(1);
        check("t5_resat", DATA_OUT, RESAT);

        // acc_clr in direct mode clears ovf only; mode switch accumulates on top.
        step(1, 8'd3, 8'd4, 16'd5, 0, 1);
        step(1, 8'd1, 8'd1, 16'd1, 1, 0);
        idle(1);
        check("t5_direct_clr_d", DATA_OUT, 17);
        check("t5_direct_clr_ovf", ovf, 0);
        idle(1);
        check("t5_switch_acc", DATA_OUT, 19);

        // Async reset with two beats in flight and ovf set.
        step(1, 8'd255, 8'd255, 16'd1024, 0, 0);
        idle(2);
        check("t6_pre_ovf", ovf, 1);
        step(1, 8'd1, 8'd1, 16'd1, 0, 0);
        step(1, 8'd2, 8'd2, 16'd2, 0, 0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_data", DATA_OUT, 0);
        check("t6_rst_valid", out_valid, 0);
        check("t6_rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            idle(1);
            check("t6_no_stale", out_valid, 0);
        end
        check("t6_data_post", DATA_OUT, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL timeout: got running expected finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_pipe_param.md
Name: mac_pipe_param

Overview:
- Parametrised, valid-qualified, pipelined multiply-add unit.
- Computes A*B + C per input beat (direct mode), or accumulates A*B + C into a running sum (accumulate mode).
- Adds a configurable multiply pipeline depth, in/out valid flags, a synchronous accumulator clear and a sticky overflow flag.
- Sits in the datapath between operand registers and downstream filter/sum logic.

Parameters:
- IN_W, 8, width of A and B in bits (unsigned).
- C_W, 16, width of C in bits (unsigned); C_W <= OUT_W.
- OUT_W, 16, width of DATA_OUT in bits; OUT_W >= 2*IN_W, checked at elaboration (fatal if violated).
- PIPE, 2, number of product pipeline stages, >= 1; total latency = PIPE+1 cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  A/B/C/mode/acc_clr are valid this cycle
- A  input  IN_W  multiplicand
- B  input  IN_W  multiplier
- C  input  C_W  addend
- mode  input  1  0 = direct (A*B+C), 1 = accumulate
- acc_clr  input  1  with in_valid: accumulator restarts from 0 for this beat; also clears ovf
- out_valid  output  1  DATA_OUT updated this cycle
- DATA_OUT  output  OUT_W  result register
- ovf  output  1  sticky overflow flag

Behaviour:
- Reset (rst_n low, async): all pipeline registers, DATA_OUT, out_valid and ovf go to 0 immediately, regardless of clk. Operation resumes on the first clk edge after rst_n rises; beats in flight are discarded.
- Stage 1: register A*B (2*IN_W bits, unsigned), C, mode, acc_clr, in_valid.
- Stages 2..PIPE: shift product, C, mode, acc_clr and valid together, so C stays aligned with its product. No stalling: one beat per cycle.
- Final stage (cycle PIPE+1), when the delayed valid is 1:
  - Direct mode: sum = zero-extended product + zero-extended C, computed at OUT_W+1 bits.
  - Accumulate mode: base = 0 if the delayed acc_clr is 1, else the current DATA_OUT; sum = base + product + C, computed at OUT_W+1 bits.
  - DATA_OUT <= sum[OUT_W-1:0].
  - out_valid <= 1.
  - If sum[OUT_W] is 1, ovf <= 1.
- When the delayed valid is 0: out_valid <= 0; DATA_OUT and ovf hold.
- ovf clear:
  - ovf clears only on reset, or when a beat with acc_clr=1 reaches the final stage.
  - If that same beat overflows, ovf ends at 1: the set wins over the clear.
- Mode switch between beats is legal:
  - A direct-mode beat overwrites DATA_OUT.
  - A following accumulate beat without acc_clr accumulates on top of that value.
- acc_clr with mode=0 only clears ovf; it has no effect on the direct result.
- Back-to-back beats: results appear on consecutive cycles, in order. Bubbles in in_valid reproduce exactly at out_valid.

Optional Feature:
- Macro MAC_PIPE_SATURATE_EN.
- Defined: when sum[OUT_W] is 1, DATA_OUT <= all ones (2^OUT_W-1) instead of the wrapped value. ovf behaves as without the macro. In accumulate mode, later beats add onto the saturated value and saturate again.
- Undefined: modulo 2^OUT_W wrap as above. No saturation logic is synthesised.

Test Plan (IN_W=8, C_W=16, OUT_W=16, PIPE=2, latency 3):
1. Direct beat: mode=0, A=3, B=4, C=5, in_valid at cycle 0 -> out_valid=1 and DATA_OUT=17 at cycle 3; out_valid=0 at cycle 4 with DATA_OUT held at 17.
2. Stream with gaps: beats (1,1,0), (2,2,1), idle, (10,10,6) on cycles 0,1,3 -> out_valid pattern 1,1,0,1 on cycles 3-6, with DATA_OUT values 1, 5, (held 5), 106.
3. Accumulate: mode=1, acc_clr=1, A=10, B=10, C=0, then acc_clr=0, A=2, B=3, C=1 -> DATA_OUT=100 then 107 on consecutive cycles.
4. Overflow: mode=0, A=255, B=255, C=1024 -> sum 66049. Without macro: DATA_OUT=513, ovf=1. With MAC_PIPE_SATURATE_EN: DATA_OUT=65535, ovf=1. In both cases ovf stays 1 through later non-overflowing direct beats.
5. Clear: after test 4, mode=1, acc_clr=1, A=1, B=1, C=0 -> DATA_OUT=1, ovf=0 at latency 3.
6. Async reset: assert rst_n mid-clock with 2 beats in flight -> DATA_OUT, out_valid and ovf read 0 before the next edge; after release, no stale out_valid pulses appear.
